// File: rtl/powlib_dpram_fifoctrl_pkg.sv
// powlib_dpram_fifoctrl_pkg: shared sizing helper for the dpram FIFO controller
package powlib_dpram_fifoctrl_pkg;
  function automatic int powlib_clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/powlib_dpram_fifoctrl_cntr.sv
// powlib_dpram_fifoctrl_cntr: index counter that advances on adv and wraps from D-1 to 0
module powlib_dpram_fifoctrl_cntr #(
  parameter int D = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] val
);
  localparam logic [W-1:0] LAST = W'(D - 1);
  always_ff @(posedge clk)
    if (!rst || clr) val <= '0;
    else if (adv) val <= (val == LAST) ? '0 : val + W'(1);
endmodule

// File: rtl/powlib_dpram_fifoctrl.sv
// powlib_dpram_fifoctrl: sequences a registered-read dual-port RAM as a first-word-fall-through FIFO
module powlib_dpram_fifoctrl
  import powlib_dpram_fifoctrl_pkg::*;
#(
  parameter int D    = 8,
  parameter int WIDX = powlib_clogb2(D),
  parameter int WCNT = powlib_clogb2(D + 1),
  parameter int AF   = D - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            invld,
  output logic            inrdy,
  output logic            outvld,
  input  logic            outrdy,
  output logic [WIDX-1:0] ram_wridx,
  output logic            ram_wrvld,
  output logic [WIDX-1:0] ram_rdidx,
  output logic            ram_rdrdy,
  output logic [WCNT-1:0] cnt,
  output logic            empty,
  output logic            af
);
  localparam logic [WCNT-1:0] FULL = WCNT'(D);
  localparam logic [WCNT-1:0] AFC  = WCNT'(AF);
  logic flush, push, issue, pop;
  assign flush     = !rst || clr;
  assign inrdy     = cnt != FULL;
  assign push      = invld && inrdy && !flush;
  // issue refills rddata whenever the head slot is free or being consumed this cycle
  assign issue     = (cnt != '0) && (!outvld || outrdy) && !flush;
  assign pop       = outvld && outrdy;
  assign ram_wrvld = push;
  assign ram_rdrdy = issue;
  assign empty     = (cnt == '0) && !outvld;
  assign af        = cnt >= AFC;
  always_ff @(posedge clk)
    if (flush) begin
      cnt    <= '0;
      outvld <= 1'b0;
    end else begin
      cnt    <= cnt + WCNT'(push) - WCNT'(issue);
      outvld <= issue ? 1'b1 : pop ? 1'b0 : outvld;
    end
  powlib_dpram_fifoctrl_cntr #(.D(D), .W(WIDX)) u_wr (
    .clk(clk), .rst(rst), .clr(clr), .adv(push), .val(ram_wridx)
  );
  powlib_dpram_fifoctrl_cntr #(.D(D), .W(WIDX)) u_rd (
    .clk(clk), .rst(rst), .clr(clr), .adv(issue), .val(ram_rdidx)
  );
endmodule

// File: tb/tb_powlib_dpram_fifoctrl.sv
// tb_powlib_dpram_fifoctrl: directed checks of the FIFO controller against a registered-read RAM
module tb_powlib_dpram_fifoctrl;
  logic       clk, rst, clr, invld, inrdy, outvld, outrdy;
  logic [1:0] ram_wridx, ram_rdidx;
  logic       ram_wrvld, ram_rdrdy, empty, af;
  logic [2:0] cnt;
  logic [7:0] wrdata, rddata;
  logic [7:0] mem [4];
  int total, bad, nxt, exp_v, wraps, maxc;

  powlib_dpram_fifoctrl #(.D(4), .AF(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .invld(invld), .inrdy(inrdy),
    .outvld(outvld), .outrdy(outrdy), .ram_wridx(ram_wridx), .ram_wrvld(ram_wrvld),
    .ram_rdidx(ram_rdidx), .ram_rdrdy(ram_rdrdy), .cnt(cnt), .empty(empty), .af(af)
  );

  always @(posedge clk) begin
    if (ram_wrvld) mem[ram_wridx] <= wrdata;
    if (ram_rdrdy) rddata <= mem[ram_rdidx];
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 0; rst = 0; clr = 0; invld = 1; outrdy = 1; wrdata = 8'h00; rddata = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'hEE;
    #2 chk("rst_wrvld", ram_wrvld, 0);
    tick(); tick();
    chk("rst_outvld", outvld, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_inrdy", inrdy, 1);
    chk("rst_empty", empty, 1);
    rst = 1; invld = 0;
    tick();
    // single word: out two cycles after push
    wrdata = 8'hA5; invld = 1;
    #2 chk("s2_wrvld", ram_wrvld, 1);
    tick(); invld = 0;
    #2 chk("s2_rdrdy", ram_rdrdy, 1);
    chk("s2_outvld_t1", outvld, 0);
    tick();
    chk("s2_outvld_t2", outvld, 1);
    chk("s2_rddata", rddata, 8'hA5);
    tick();
    chk("s2_empty", empty, 1);
    chk("s2_outvld_t3", outvld, 0);
    // fill with consumer stalled
    outrdy = 0;
    for (int i = 0; i < 5; i++) begin
      wrdata = 8'(i + 1); invld = 1;
      #2 chk("s3_push", ram_wrvld, 1);
      tick();
      if (i == 2) begin chk("s3_cnt2", cnt, 2); chk("s3_af_lo", af, 0); end
      if (i == 3) begin chk("s3_cnt3", cnt, 3); chk("s3_af_hi", af, 1); end
    end
    chk("s3_cnt4", cnt, 4);
    chk("s3_inrdy", inrdy, 0);
    chk("s3_af", af, 1);
    wrdata = 8'h06; invld = 1;
    #2 chk("s3_refuse", ram_wrvld, 0);
    chk("s3_outvld", outvld, 1);
    chk("s3_head", rddata, 8'h01);
    tick();
    chk("s3_cnt_hold", cnt, 4);
    // drain while pushing 06..0B
    nxt = 6; exp_v = 1; wraps = 0; maxc = 0; outrdy = 1;
    for (int c = 0; c < 40 && exp_v <= 8'h0B; c++) begin
      invld = (nxt <= 8'h0B); wrdata = 8'(nxt);
      #2;
      if (int'(cnt) > maxc) maxc = int'(cnt);
      if (ram_wrvld) begin
        if (ram_wridx == 2'd3) wraps++;
        nxt++;
      end
      if (outvld) begin
        chk("s4_order", rddata, exp_v);
        exp_v++;
      end
      tick();
    end
    invld = 0;
    chk("s4_all_out", exp_v, 8'h0C);
    chk("s4_wraps", wraps, 2);
    chk("s4_maxcnt", maxc, 4);
    chk("s4_empty", empty, 1);
    // streaming
    nxt = 8'h20; exp_v = 8'h20;
    for (int i = 0; i < 36; i++) begin
      invld = 1; wrdata = 8'(nxt);
      #2;
      if (ram_wrvld) nxt++;
      if (i >= 2) begin
        chk("s5_push", ram_wrvld, 1);
        chk("s5_outvld", outvld, 1);
        chk("s5_cnt", cnt, 1);
        chk("s5_data", rddata, exp_v);
        exp_v++;
      end
      tick();
    end
    // flush with cnt=3 and a head word
    outrdy = 0; wrdata = 8'h55;
    tick(); tick();
    chk("s6_cnt3", cnt, 3);
    chk("s6_outvld", outvld, 1);
    clr = 1; invld = 1; outrdy = 1; wrdata = 8'h99;
    #2 chk("s6_wrvld", ram_wrvld, 0);
    chk("s6_rdrdy", ram_rdrdy, 0);
    tick();
    clr = 0; invld = 0;
    chk("s6_cnt0", cnt, 0);
    chk("s6_outvld0", outvld, 0);
    chk("s6_empty", empty, 1);
    chk("s6_inrdy", inrdy, 1);
    tick();
    chk("s6_lost", empty, 1);
    wrdata = 8'h77; invld = 1;
    tick(); invld = 0;
    tick();
    chk("s6_new_vld", outvld, 1);
    chk("s6_new_data", rddata, 8'h77);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
